// File: rtl/pe_channel_scheduler.sv
// Time-multiplexed pre-emphasis engine: y[n] = x[n] - alpha*x[n-1], round-robin shared across NCH channels.
// Optional runtime coefficient register enabled by defining PE_SCHED_COEF_EN.
module pe_channel_scheduler #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int ALPHA = 30146,
    parameter int CW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_ch,
    input  logic             out_ready,
    input  logic             flush,
`ifdef PE_SCHED_COEF_EN
    input  logic [15:0]      coef_in,
    input  logic             coef_we,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, SUB, OUT} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         rr_ptr, gnt;
    logic                  gnt_found, grant_ok, do_flush, coef_load, pend_flush;
    logic [W-1:0]          hist [NCH];
    logic signed [W-1:0]   x, xp, coef;
    logic [CW-1:0]         ch;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          scaled, sat;
    logic [W:0]            diff;

`ifdef PE_SCHED_COEF_EN
    assign coef_load = coef_we && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef <= W'(ALPHA);
        end else if (coef_load) begin
            coef <= W'(coef_in);
        end
    end
`else
    assign coef      = W'(ALPHA);
    assign coef_load = 1'b0;
`endif

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_found && in_valid[(int'(rr_ptr) + k) % NCH]) begin
                gnt_found = 1'b1;
                gnt       = CW'((int'(rr_ptr) + k) % NCH);
            end
        end
    end

    assign do_flush = (state == IDLE) && (flush || pend_flush);
    assign grant_ok = (state == IDLE) && gnt_found && !do_flush && !coef_load;
    assign busy     = (state != IDLE);

    always_comb begin
        in_ready = '0;
        if (grant_ok && !rst) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Q0.15 product back to sample scale, then saturate the W+1 bit difference.
    always_comb begin
        scaled = prod[2*W-2:W-1];
        diff   = {x[W-1], x} - {scaled[W-1], scaled};
        sat    = diff[W-1:0];
        if (diff[W] != diff[W-1]) begin
            sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ok) state_nxt = MUL;
            MUL:     state_nxt = SUB;
            SUB:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            pend_flush <= 1'b0;
            x          <= '0;
            xp         <= '0;
            ch         <= '0;
            prod       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            for (int i = 0; i < NCH; i++) hist[i] <= '0;
        end else begin
            state <= state_nxt;
            if (do_flush) begin
                pend_flush <= 1'b0;
                for (int i = 0; i < NCH; i++) hist[i] <= '0;
            end else if (flush && state != IDLE) begin
                pend_flush <= 1'b1;
            end
            case (state)
                IDLE: if (grant_ok) begin
                    x         <= in_data[int'(gnt)*W +: W];
                    xp        <= hist[gnt];
                    ch        <= gnt;
                    hist[gnt] <= in_data[int'(gnt)*W +: W];
                    rr_ptr    <= (gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1;
                end
                MUL: prod <= {{W{coef[W-1]}}, coef} * {{W{xp[W-1]}}, xp};
                SUB: begin
                    out_data  <= sat;
                    out_ch    <= ch;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_channel_scheduler.sv
// Directed bench for pe_channel_scheduler; define PE_SCHED_COEF_EN to also exercise the coefficient register.
module tb_pe_channel_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
    logic        flush;
    logic        busy;
`ifdef PE_SCHED_COEF_EN
    logic [15:0] coef_in;
    logic        coef_we;
`endif

    int checks = 0;
    int errors = 0;

    pe_channel_scheduler #(.NCH(4), .W(16), .ALPHA(30146)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .flush(flush),
`ifdef PE_SCHED_COEF_EN
        .coef_in(coef_in), .coef_we(coef_we),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic send(input int c, input logic signed [15:0] d);
        logic ok;
        ok = 1'b0;
        in_data[c*16 +: 16] = d;
        in_valid[c] = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready[c]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("grant_timeout", 32'(ok), 1);
        if (ok) step();
        in_valid[c] = 1'b0;
    endtask

    task automatic get_out(input string tag, input logic signed [15:0] exp_d, input int exp_c);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_timeout"}, 32'(ok), 1);
        chk({tag, "_data"}, 32'($signed(out_data)), 32'(exp_d));
        chk({tag, "_ch"}, 32'(out_ch), exp_c);
        step();
    endtask

    initial begin
        logic [15:0] hold_d;
        rst = 1'b1;
        in_valid = 4'hF;
        in_data = '0;
        out_ready = 1'b1;
        flush = 1'b0;
`ifdef PE_SCHED_COEF_EN
        coef_in = '0;
        coef_we = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        in_valid = 4'h0;
        step();
        rst = 1'b0;
        step();

        // first sample and exact latency
        in_data[15:0] = 16'd1000;
        in_valid[0] = 1'b1;
        #1;
        chk("first_grant", 32'(in_ready), 1);
        step();
        in_valid[0] = 1'b0;
        chk("lat_e0_valid", 32'(out_valid), 0);
        chk("lat_e0_busy", 32'(busy), 1);
        chk("lat_e0_ready", 32'(in_ready), 0);
        step();
        chk("lat_e1_valid", 32'(out_valid), 0);
        step();
        chk("lat_e2_valid", 32'(out_valid), 1);
        chk("first_data", 32'($signed(out_data)), 1000);
        chk("first_ch", 32'(out_ch), 0);
        step();
        chk("first_done_valid", 32'(out_valid), 0);
        chk("first_done_busy", 32'(busy), 0);
        send(0, 16'sd1000);
        get_out("second", 16'sd81, 0);

        // saturation both directions
        send(1, -16'sd32768);
        get_out("sat1_a", -16'sd32768, 1);
        send(1, 16'sd32767);
        get_out("sat1_b", 16'sd32767, 1);
        send(2, 16'sd32767);
        get_out("sat2_a", 16'sd32767, 2);
        send(2, -16'sd32768);
        get_out("sat2_b", -16'sd32768, 2);

        // round robin from reset, each channel on its own history
        do_reset();
        in_data = {16'sd400, -16'sd300, 16'sd200, 16'sd100};
        in_valid = 4'hF;
        get_out("rr0", 16'sd100, 0);
        get_out("rr1", 16'sd200, 1);
        get_out("rr2", -16'sd300, 2);
        get_out("rr3", 16'sd400, 3);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        in_valid = 4'h0;
        get_out("rr4", 16'sd9, 0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        send(1, 16'sd1234);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        in_data[47:32] = 16'd77;
        in_valid[2] = 1'b1;
        hold_d = out_data;
        chk("bp_first_data", 32'(out_data), 1234);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(hold_d));
            chk("bp_ch", 32'(out_ch), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_busy", 32'(busy), 0);
        chk("bp_next_grant", 32'(in_ready), 4);
        in_valid[2] = 1'b0;
        step();
        chk("bp_no_grant", 32'(busy), 0);

        // flush during MUL is deferred to the next IDLE cycle
        do_reset();
        send(3, 16'sd500);
        chk("fl_in_mul", 32'(busy), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid[3] = 1'b1;
        get_out("fl_a", 16'sd500, 3);
        chk("fl_idle_busy", 32'(busy), 0);
        chk("fl_blocked", 32'(in_ready), 0);
        step();
        chk("fl_grant", 32'(in_ready), 8);
        step();
        in_valid[3] = 1'b0;
        get_out("fl_b", 16'sd500, 3);

        // reset during SUB
        send(3, 16'sd500);
        step();
        rst = 1'b1;
        #1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_data", 32'(out_data), 0);
        #2;
        rst = 1'b0;
        step();
        send(3, 16'sd500);
        get_out("rs_after", 16'sd500, 3);

`ifdef PE_SCHED_COEF_EN
        do_reset();
        coef_in = 16'd0;
        coef_we = 1'b1;
        in_data[15:0] = 16'd1000;
        in_valid[0] = 1'b1;
        #1;
        chk("coef_blocks_grant", 32'(in_ready), 0);
        step();
        coef_we = 1'b0;
        send(0, 16'sd1000);
        get_out("coef_a", 16'sd1000, 0);
        send(0, 16'sd2000);
        get_out("coef_b", 16'sd2000, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
